// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data load/store. Level-start / pulse-done handshake on both sides.
// Optional watchdog: define MEM_PORT_ARB_TIMEOUT_EN to abort a BUSY
// transaction after TIMEOUT_CYCLES without mem_done (reports bus_err).
module mem_port_arbiter #(
  parameter int unsigned AW             = 64,
  parameter int unsigned DW             = 64,
  parameter int unsigned ARB_MODE       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_start,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_start,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic [1:0]    mem_size,
  input  logic          mem_done,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err,
  output logic          owner
);

  localparam logic [1:0] SIZE_DWORD = 2'b11;
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          rr_last, rr_last_nxt;
  logic          grant_data;
  logic          mem_start_nxt, mem_we_nxt, owner_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic [1:0]    mem_size_nxt;
  logic          i_done_nxt, d_done_nxt, bus_err_nxt;
  logic [DW-1:0] i_rdata_nxt, d_rdata_nxt;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW     = (CW_RAW > 8) ? CW_RAW : 8;
  logic [CW-1:0] cnt, cnt_nxt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{32'(TIMEOUT_CYCLES), SIZE_DWORD};
`endif

  // Tie-break: fixed data priority, or alternate against the last grant
  always_comb begin
    grant_data = 1'b0;
    if (d_start && !i_start) begin
      grant_data = 1'b1;
    end else if (d_start && i_start) begin
      grant_data = (ARB_MODE == 0) ? 1'b1 : !rr_last;
    end
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_nxt     = state;
    rr_last_nxt   = rr_last;
    mem_start_nxt = mem_start;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_we_nxt    = mem_we;
    mem_size_nxt  = mem_size;
    owner_nxt     = owner;
    i_done_nxt    = 1'b0;
    d_done_nxt    = 1'b0;
    bus_err_nxt   = 1'b0;
    i_rdata_nxt   = i_rdata;
    d_rdata_nxt   = d_rdata;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    cnt_nxt       = cnt;
`endif
    case (state)
      IDLE: begin
        if (i_start || d_start) begin
          state_nxt     = BUSY;
          mem_start_nxt = 1'b1;
          owner_nxt     = grant_data;
          rr_last_nxt   = grant_data;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
          cnt_nxt       = '0;
`endif
          if (grant_data) begin
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
            mem_we_nxt    = d_we;
            mem_size_nxt  = d_size;
          end else begin
            mem_addr_nxt  = i_addr;
            mem_wdata_nxt = '0;
            mem_we_nxt    = 1'b0;
            mem_size_nxt  = SIZE_WORD;
          end
        end
      end
      BUSY: begin
        if (mem_done) begin
          state_nxt     = RELEASE;
          mem_start_nxt = 1'b0;
          if (owner) begin
            d_done_nxt  = 1'b1;
            d_rdata_nxt = mem_rdata;
          end else begin
            i_done_nxt  = 1'b1;
            i_rdata_nxt = mem_rdata;
          end
        end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt     = RELEASE;
          mem_start_nxt = 1'b0;
          bus_err_nxt   = 1'b1;
          if (owner) begin
            d_done_nxt  = 1'b1;
            d_rdata_nxt = '0;
          end else begin
            i_done_nxt  = 1'b1;
            i_rdata_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt     = IDLE;
        mem_start_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_last   <= 1'b0;
      mem_start <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_size  <= SIZE_WORD;
      owner     <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      bus_err   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      rr_last   <= rr_last_nxt;
      mem_start <= mem_start_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_we    <= mem_we_nxt;
      mem_size  <= mem_size_nxt;
      owner     <= owner_nxt;
      i_done    <= i_done_nxt;
      d_done    <= d_done_nxt;
      bus_err   <= bus_err_nxt;
      i_rdata   <= i_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
    end
  end

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  // Watchdog counter for the current BUSY transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dut0 uses fixed priority, dut1
// round-robin. Inputs are driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start, d_start, d_we, mem_done;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [1:0]    d_size;

  logic          i_done0, d_done0, mem_start0, mem_we0, bus_err0, owner0;
  logic [DW-1:0] i_rdata0, d_rdata0, mem_wdata0;
  logic [AW-1:0] mem_addr0;
  logic [1:0]    mem_size0;

  logic          i_done1, d_done1, mem_start1, mem_we1, bus_err1, owner1;
  logic [DW-1:0] i_rdata1, d_rdata1, mem_wdata1;
  logic [AW-1:0] mem_addr1;
  logic [1:0]    mem_size1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .ARB_MODE(0), .TIMEOUT_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset),
    .i_start(i_start), .i_addr(i_addr), .i_done(i_done0), .i_rdata(i_rdata0),
    .d_start(d_start), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_size(d_size), .d_done(d_done0), .d_rdata(d_rdata0),
    .mem_start(mem_start0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_we(mem_we0), .mem_size(mem_size0), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .bus_err(bus_err0), .owner(owner0)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .ARB_MODE(1), .TIMEOUT_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset),
    .i_start(i_start), .i_addr(i_addr), .i_done(i_done1), .i_rdata(i_rdata1),
    .d_start(d_start), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_size(d_size), .d_done(d_done1), .d_rdata(d_rdata1),
    .mem_start(mem_start1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_we(mem_we1), .mem_size(mem_size1), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .bus_err(bus_err1), .owner(owner1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Hard time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] rr_exp;
    reset = 1'b1; i_start = 0; d_start = 0; d_we = 0; mem_done = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; d_size = 2'b00;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_mem_start", mem_start0, 1'b0);
    check("rst_mem_size",  mem_size0, 2'b10);
    check("rst_mem_addr",  mem_addr0, '0);
    check("rst_owner",     owner0, 1'b0);
    check("rst_i_done",    i_done0, 1'b0);
    check("rst_bus_err",   bus_err0, 1'b0);

    // Fetch only
    i_start = 1; i_addr = 64'h1000;
    tick();
    check("f_mem_start", mem_start0, 1'b1);
    check("f_mem_addr",  mem_addr0, 64'h1000);
    check("f_mem_we",    mem_we0, 1'b0);
    check("f_mem_size",  mem_size0, 2'b10);
    check("f_owner",     owner0, 1'b0);
    tick(); tick();
    check("f_hold_start", mem_start0, 1'b1);
    mem_done = 1; mem_rdata = 64'h00500093;
    tick();
    check("f_i_done",    i_done0, 1'b1);
    check("f_i_rdata",   i_rdata0, 64'h00500093);
    check("f_d_done",    d_done0, 1'b0);
    check("f_start_low", mem_start0, 1'b0);
    mem_done = 0; i_start = 0;
    tick();
    check("f_i_done_pulse", i_done0, 1'b0);
    check("f_i_rdata_hold", i_rdata0, 64'h00500093);

    // Tie under fixed priority: data first, fetch after
    i_start = 1; i_addr = 64'h3000;
    d_start = 1; d_addr = 64'h2000; d_we = 1; d_size = 2'b11; d_wdata = 64'hDEADBEEF;
    tick();
    check("t0_owner",  owner0, 1'b1);
    check("t0_we",     mem_we0, 1'b1);
    check("t0_size",   mem_size0, 2'b11);
    check("t0_addr",   mem_addr0, 64'h2000);
    check("t0_wdata",  mem_wdata0, 64'hDEADBEEF);
    mem_done = 1; mem_rdata = 64'h55;
    tick();
    check("t0_d_done", d_done0, 1'b1);
    check("t0_i_done", i_done0, 1'b0);
    check("t0_d_rdata", d_rdata0, 64'h55);
    mem_done = 0; d_start = 0;
    tick();
    check("t0_gap_start", mem_start0, 1'b0);
    tick();
    check("t0_f_start", mem_start0, 1'b1);
    check("t0_f_owner", owner0, 1'b0);
    check("t0_f_addr",  mem_addr0, 64'h3000);
    check("t0_f_we",    mem_we0, 1'b0);
    check("t0_f_size",  mem_size0, 2'b10);
    check("t0_f_wdata", mem_wdata0, 64'h0);
    mem_done = 1; mem_rdata = 64'h13;
    tick();
    check("t0_f_done",  i_done0, 1'b1);
    check("t0_f_rdata", i_rdata0, 64'h13);
    check("t0_d_hold",  d_rdata0, 64'h55);
    mem_done = 0; i_start = 0;
    tick();

    // Round-robin on three back-to-back ties; last grant was fetch
    rr_exp = 3'b101;
    i_start = 1; d_start = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rr_start", mem_start1, 1'b1);
      check("rr_owner", owner1, rr_exp[k]);
      mem_done = 1; mem_rdata = 64'(k);
      tick();
      if (rr_exp[k]) check("rr_d_done", d_done1, 1'b1);
      else           check("rr_i_done", i_done1, 1'b1);
      mem_done = 0;
      if (rr_exp[k]) d_start = 0; else i_start = 0;
      tick();
      i_start = 1; d_start = 1;
    end
    i_start = 0; d_start = 0;
    tick(); tick();

    // Reset in the middle of BUSY, then a stale mem_done
    d_we = 0; i_start = 1; i_addr = 64'h4000;
    tick();
    check("rb_start", mem_start0, 1'b1);
    tick(); tick();
    reset = 1;
    tick();
    check("rb_start_low", mem_start0, 1'b0);
    check("rb_addr_rst",  mem_addr0, 64'h0);
    check("rb_rdata_rst", i_rdata0, 64'h0);
    check("rb_size_rst",  mem_size0, 2'b10);
    reset = 0; i_start = 0; mem_done = 1; mem_rdata = 64'hBAD;
    tick();
    check("rb_no_i_done", i_done0, 1'b0);
    check("rb_no_d_done", d_done0, 1'b0);
    check("rb_idle",      mem_start0, 1'b0);
    // Spurious mem_done while idle
    tick();
    check("sp_no_done",  i_done0, 1'b0);
    check("sp_rdata",    i_rdata0, 64'h0);
    check("sp_d_rdata",  d_rdata0, 64'h0);
    mem_done = 0;
    tick();

    // Unanswered request: watchdog abort if enabled, otherwise wait
    i_start = 1; i_addr = 64'h5000;
    tick();
    check("to_start", mem_start0, 1'b1);
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      check("to_busy", mem_start0, 1'b1);
    end
    tick();
    check("to_start_low", mem_start0, 1'b0);
    check("to_i_done",    i_done0, 1'b1);
    check("to_bus_err",   bus_err0, 1'b1);
    check("to_rdata",     i_rdata0, 64'h0);
`else
    for (int k = 0; k < 6; k++) begin
      tick();
      check("nt_busy",    mem_start0, 1'b1);
      check("nt_bus_err", bus_err0, 1'b0);
    end
    mem_done = 1; mem_rdata = 64'h42;
    tick();
    check("nt_i_done", i_done0, 1'b1);
    check("nt_rdata",  i_rdata0, 64'h42);
    check("nt_err",    bus_err0, 1'b0);
    mem_done = 0;
`endif
    i_start = 0;
    tick();
    check("nx_err_pulse", bus_err0, 1'b0);
    // Following load is served normally
    d_start = 1; d_addr = 64'h6000; d_we = 0; d_size = 2'b10;
    tick();
    check("nx_start", mem_start0, 1'b1);
    check("nx_owner", owner0, 1'b1);
    check("nx_addr",  mem_addr0, 64'h6000);
    mem_done = 1; mem_rdata = 64'h77;
    tick();
    check("nx_d_done", d_done0, 1'b1);
    check("nx_d_rdata", d_rdata0, 64'h77);
    check("nx_bus_err", bus_err0, 1'b0);
    mem_done = 0; d_start = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters:
  - Instruction fetch (the control unit's FETCH phase).
  - Data load/store (the load/store FSM).
- Sits between the control path and the memory block, using the same level-start / pulse-done handshake on both sides.
- Arbitrates, latches the winning request, holds mem_start until mem_done, then returns a one-cycle done pulse and registered read data to the owner.

Parameters:
- AW, 64, address width
- DW, 64, data width
- ARB_MODE, 0, 0 = fixed priority (data wins ties); 1 = round-robin on ties
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_start  in  1  fetch request, level; held until i_done
- i_addr  in  AW  fetch address
- i_done  out  1  one-cycle fetch-complete pulse
- i_rdata  out  DW  fetch read data, valid while i_done=1
- d_start  in  1  data request, level; held until d_done
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  access size (00 b, 01 h, 10 w, 11 d)
- d_done  out  1  one-cycle data-complete pulse
- d_rdata  out  DW  load data, valid while d_done=1
- mem_start  out  1  memory request, level
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched store data
- mem_we  out  1  latched write enable (0 for fetch)
- mem_size  out  2  latched size (10 for fetch)
- mem_done  in  1  memory completion pulse
- mem_rdata  in  DW  memory read data, valid with mem_done
- bus_err  out  1  one-cycle timeout pulse, concurrent with owner done
- owner  out  1  0 = fetch owns port, 1 = data; valid when mem_start=1

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high. All registered outputs are registers; no combinational path from inputs to mem_* or *_done.
- Reset values:
  - State goes to IDLE.
  - mem_start, i_done, d_done, bus_err, mem_we, owner = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0; mem_size = 10.
  - rr_last = 0 (last grant went to fetch).
  - Reset mid-transaction drops mem_start the next edge and discards any in-flight mem_done. The memory block shares the reset.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - Samples i_start/d_start.
  - With any request: latch the winner's addr/wdata/we/size, set owner, set mem_start=1, go to BUSY. mem_start rises the cycle after the request is sampled.
  - Fetch latches mem_we=0, mem_size=10, mem_wdata=0.
- Arbitration on a tie:
  - ARB_MODE=0: data wins.
  - ARB_MODE=1: the requester not granted last wins; rr_last updates on every grant.
  - A single requester always wins.
- BUSY:
  - mem_start held at 1 and mem_* held stable; requester inputs are ignored.
  - On mem_done: capture mem_rdata into the owner's rdata, pulse the owner's done the next cycle, drop mem_start, go to RELEASE.
- RELEASE: lasts one cycle; done=1 this cycle. The requester must drop start in the cycle it sees done. Requests are ignored here; next state is IDLE.
- The losing requester stays pending; it is granted from IDLE at the earliest 2 cycles after the winner's done.
- Minimum latency: request at cycle N gives mem_start at N+1; mem_done at M gives done at M+1; the port is free in IDLE at M+2.
- mem_done outside BUSY is ignored.
- rdata registers hold their value after done until the next completion for the same requester.

Optional Feature:
- Macro: MEM_PORT_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without mem_done: drop mem_start, pulse owner done with rdata=0 and bus_err=1 in the same cycle, go to RELEASE.
  - mem_done arriving in the same cycle as the timeout takes precedence: normal completion, bus_err=0.
- Undefined: no counter; BUSY waits indefinitely; bus_err is constantly 0.

Test Plan:
- Fetch only: i_start=1, i_addr=0x1000; mem_done after 3 cycles with rdata=0x00500093 -> mem_start at N+1, mem_addr=0x1000, mem_we=0, mem_size=10; i_done pulses 1 cycle with i_rdata=0x00500093; d_done stays 0.
- Tie, ARB_MODE=0: i_start and d_start both rise same cycle, d_addr=0x2000, d_we=1, d_size=11, d_wdata=0xDEADBEEF -> data is served first with mem_we=1, mem_size=11; fetch is granted 2 cycles after d_done.
- Tie, ARB_MODE=1, three back-to-back ties with rr_last=0 -> grant order data, fetch, data; owner toggles accordingly.
- Reset mid-BUSY: assert reset 2 cycles after mem_start, then mem_done arrives post-reset -> mem_start=0 the next edge, no done pulse, state IDLE, outputs at reset values.
- Spurious mem_done in IDLE -> no done pulse, no state change, rdata unchanged.
- With MEM_PORT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_done never returned -> mem_start drops after 4 BUSY cycles; owner done=1, bus_err=1, rdata=0; next request is accepted normally.
